// File: rtl/load_use_scoreboard_if.sv
// Decoder-side handshake bundle for the load-use scoreboard.
// Combinational bundle; no latency of its own.
// No backpressure of its own; mem_busy carries the memory hold request.
// Optional stall_cycles member exists only when LOAD_USE_STALL_CNT_EN is defined.
interface load_use_scoreboard_if #(
    parameter int REG_W = 5
);
    logic [REG_W-1:0] IFID_Rs;
    logic [REG_W-1:0] IFID_Rt;
    logic             IFID_uses_Rs;
    logic             IFID_uses_Rt;
    logic             IFID_mem_read;
    logic [REG_W-1:0] IFID_dest;
    logic             flush;
    logic             mem_busy;
    logic             sel_signal;
    logic             IFID_Ld;
    logic             pc_load;
    logic             IDEX_Ld;
    logic             stall;
`ifdef LOAD_USE_STALL_CNT_EN
    logic [15:0]      stall_cycles;
`endif

    // Decoder / pipeline side: drives ID-stage info, receives enables.
    modport master (
        output IFID_Rs, IFID_Rt, IFID_uses_Rs, IFID_uses_Rt,
        output IFID_mem_read, IFID_dest, flush, mem_busy,
`ifdef LOAD_USE_STALL_CNT_EN
        input  stall_cycles,
`endif
        input  sel_signal, IFID_Ld, pc_load, IDEX_Ld, stall
    );

    // Scoreboard side.
    modport slave (
        input  IFID_Rs, IFID_Rt, IFID_uses_Rs, IFID_uses_Rt,
        input  IFID_mem_read, IFID_dest, flush, mem_busy,
`ifdef LOAD_USE_STALL_CNT_EN
        output stall_cycles,
`endif
        output sel_signal, IFID_Ld, pc_load, IDEX_Ld, stall
    );
endinterface

// File: rtl/load_use_scoreboard.sv
// Load-use hazard scoreboard: LOAD_LAT-deep shift of in-flight load destinations.
// Enables/stall are combinational from ID inputs and slot state; slots update each clk.
// mem_busy freezes every pipe enable and holds the scoreboard.
// Optional macro LOAD_USE_STALL_CNT_EN adds a saturating stall_cycles counter.
module load_use_scoreboard #(
    parameter int REG_W           = 5,
    parameter int LOAD_LAT        = 1,
    parameter bit ZERO_REG_IGNORE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    load_use_scoreboard_if.slave  bus
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
    } slot_t;

    // slots[k] holds the load that entered EX k advancing cycles ago.
    slot_t slots [0:LOAD_LAT-1];

    logic hazard;
    logic zero_dest;
    logic load_accept;
    logic sel_q;
    logic ifid_ld_q;
    logic pc_ld_q;
    logic idex_ld_q;
    logic stall_q;

    // Any valid in-flight load whose destination is read by the ID instruction.
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < LOAD_LAT; k++) begin
            if (slots[k].valid &&
                ((bus.IFID_uses_Rs && (slots[k].dest == bus.IFID_Rs)) ||
                 (bus.IFID_uses_Rt && (slots[k].dest == bus.IFID_Rt)))) begin
                hazard = 1'b1;
            end
        end
    end

    // A load is tracked only if it actually advances into EX and writes a real register.
    assign zero_dest   = ZERO_REG_IGNORE && (bus.IFID_dest == '0);
    assign load_accept = bus.IFID_mem_read && !bus.flush && !hazard && !zero_dest;

    // Priority: reset, memory hold, flush (beats hazard), hazard, normal flow.
    always_comb begin
        sel_q     = 1'b1;
        ifid_ld_q = 1'b1;
        pc_ld_q   = 1'b1;
        idex_ld_q = 1'b1;
        stall_q   = 1'b0;
        if (!rst) begin
            if (bus.mem_busy) begin
                pc_ld_q   = 1'b0;
                ifid_ld_q = 1'b0;
                idex_ld_q = 1'b0;
            end else if (bus.flush) begin
                sel_q     = 1'b0;
            end else if (hazard) begin
                pc_ld_q   = 1'b0;
                ifid_ld_q = 1'b0;
                sel_q     = 1'b0;
                stall_q   = 1'b1;
            end
        end
    end

    assign bus.sel_signal = sel_q;
    assign bus.IFID_Ld    = ifid_ld_q;
    assign bus.pc_load    = pc_ld_q;
    assign bus.IDEX_Ld    = idex_ld_q;
    assign bus.stall      = stall_q;

    // Age the scoreboard one slot per advancing cycle; hold while memory is busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LOAD_LAT; k++) begin
                slots[k] <= '0;
            end
        end else if (!bus.mem_busy) begin
            for (int k = LOAD_LAT - 1; k > 0; k--) begin
                slots[k] <= slots[k-1];
            end
            slots[0] <= {load_accept, bus.IFID_dest};
        end
    end

`ifdef LOAD_USE_STALL_CNT_EN
    logic [15:0] stall_cnt;

    // Count hazard-stall cycles, saturating rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_q && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign bus.stall_cycles = stall_cnt;
`endif

endmodule
